// File: rtl/st_unit.sv
// st_unit: store unit driving word/byte writes to data memory over req/ack; byte stores use RMW unless ST_BYTE_MASK_EN.
// Latency (zero-wait memory): word store done 2 cycles after start, RMW byte store 3; ST_BYTE_MASK_EN makes byte = word.
// Backpressure: memory stalls by withholding mem_ack (bounded by TO_CYCLES); start is ignored while busy, never queued.
module st_unit #(
  parameter int ADDR_W    = 8,
  parameter int TO_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       ins,
  input  logic [15:0]       A_in,
  input  logic [15:0]       B_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_be,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state, state_nxt;
  logic [15:0]       src_q, src_nxt;
  logic              hi_q, hi_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              timeout;

  logic              req_nxt, we_nxt, done_nxt, err_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [15:0]       wdata_nxt;
  logic [1:0]        be_nxt;
  logic [15:0]       src_in;

  logic              unused_ins;
  assign unused_ins = ^{ins[15:12], ins[8]};

  assign src_in  = ins[11] ? B_in : A_in;
  assign busy    = (state != IDLE);
  // The last waiting cycle of a request is the one where the counter already reads TO_CYCLES-1.
  assign timeout = (TO_CYCLES != 0) && (cnt_q == CNT_W'(TO_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    src_nxt   = src_q;
    hi_nxt    = hi_q;
    cnt_nxt   = cnt_q;
    req_nxt   = mem_req;
    we_nxt    = mem_we;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    be_nxt    = mem_be;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          src_nxt  = src_in;
          hi_nxt   = ins[9];
          cnt_nxt  = '0;
          req_nxt  = 1'b1;
          addr_nxt = ins[ADDR_W-1:0];
          if (!ins[10]) begin
            state_nxt = WR;
            we_nxt    = 1'b1;
            wdata_nxt = src_in;
            be_nxt    = 2'b11;
          end else begin
`ifdef ST_BYTE_MASK_EN
            state_nxt = WR;
            we_nxt    = 1'b1;
            wdata_nxt = {src_in[7:0], src_in[7:0]};
            be_nxt    = ins[9] ? 2'b10 : 2'b01;
`else
            state_nxt = RD;
            we_nxt    = 1'b0;
            wdata_nxt = '0;
            be_nxt    = 2'b11;
`endif
          end
        end
      end

      RD: begin
        if (mem_ack) begin
          // Merge happens straight into the write-data register; it doubles as the read capture.
          state_nxt = WR;
          cnt_nxt   = '0;
          we_nxt    = 1'b1;
          be_nxt    = 2'b11;
          wdata_nxt = hi_q ? {src_q[7:0], mem_rdata[7:0]} : {mem_rdata[15:8], src_q[7:0]};
        end else if (timeout) begin
          state_nxt = DONE;
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
          addr_nxt  = '0;
          wdata_nxt = '0;
          be_nxt    = '0;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end

      WR: begin
        if (mem_ack || timeout) begin
          state_nxt = DONE;
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
          addr_nxt  = '0;
          wdata_nxt = '0;
          be_nxt    = '0;
          done_nxt  = 1'b1;
          err_nxt   = !mem_ack;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
        we_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      src_q     <= '0;
      hi_q      <= 1'b0;
      cnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      src_q     <= src_nxt;
      hi_q      <= hi_nxt;
      cnt_q     <= cnt_nxt;
      mem_req   <= req_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      mem_be    <= be_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_st_unit.sv
// Randomized bench for st_unit: a memory responder with programmable wait states and a
// word-level memory model that predicts contents, write beats, latency and abort outcomes.
module tb_st_unit;
  localparam int TO = 4;
  localparam int NEVER = 99;
`ifdef ST_BYTE_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] ins = '0, A_in = '0, B_in = '0, mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy, done, err, mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;

  int total = 0;
  int bad = 0;

  logic [15:0] bmem [256];
  logic [15:0] rmem [256];

  always #5 clk = ~clk;

  st_unit #(.ADDR_W(8), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ins(ins), .A_in(A_in), .B_in(B_in),
    .busy(busy), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // rdw/wrw: wait cycles before ack in the read/write phase; >= TO means never ack.
  task automatic do_store(input logic [15:0] i, input logic [15:0] a, input logic [15:0] b,
                          input int rdw, input int wrw);
    logic [15:0] src, old, merged, exp_wd, wd;
    logic [7:0]  ad, wa;
    logic [1:0]  exp_be, wbe;
    logic        byte_st, hi, has_rd, rd_to, wr_to, exp_err, err_seen, prev_req, prev_we;
    int          exp_req, exp_done, exp_nwr, reqc, nwr, phase_cyc, done_cyc, cyc, w;

    src     = i[11] ? b : a;
    ad      = i[7:0];
    byte_st = i[10];
    hi      = i[9];
    has_rd  = byte_st && !MASK;
    old     = rmem[ad];
    merged  = !byte_st ? src : (hi ? {src[7:0], old[7:0]} : {old[15:8], src[7:0]});
    exp_wd  = (byte_st && MASK) ? {src[7:0], src[7:0]} : merged;
    exp_be  = (byte_st && MASK) ? (hi ? 2'b10 : 2'b01) : 2'b11;
    rd_to   = has_rd && (rdw >= TO);
    wr_to   = !rd_to && (wrw >= TO);
    exp_err = rd_to || wr_to;
    exp_nwr = exp_err ? 0 : 1;
    exp_req = (has_rd ? (rd_to ? TO : rdw + 1) : 0) + (rd_to ? 0 : (wr_to ? TO : wrw + 1));
    exp_done = 1 + exp_req;
    if (!exp_err) rmem[ad] = merged;

    reqc = 0; nwr = 0; phase_cyc = 0; done_cyc = -1; err_seen = 1'b0;
    prev_req = 1'b0; prev_we = 1'b0; wa = '0; wd = '0; wbe = '0;

    @(negedge clk);
    start = 1'b1; ins = i; A_in = a; B_in = b; mem_ack = 1'b0;
    @(negedge clk);
    start = 1'b0; ins = 16'($urandom); A_in = 16'($urandom); B_in = 16'($urandom);
    cyc = 1;
    while (cyc < 64 && done_cyc < 0) begin
      mem_ack = 1'b0;
      mem_rdata = 16'($urandom);
      if (done) begin
        done_cyc = cyc;
        err_seen = err;
        mem_ack  = 1'($urandom_range(0, 1));
        start    = 1'($urandom_range(0, 1));
      end else if (mem_req) begin
        reqc++;
        if (!prev_req || mem_we != prev_we) phase_cyc = 0;
        else phase_cyc++;
        w = mem_we ? wrw : rdw;
        if (phase_cyc == w) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            nwr++;
            wa = mem_addr; wd = mem_wdata; wbe = mem_be;
            if (mem_be[1]) bmem[mem_addr][15:8] = mem_wdata[15:8];
            if (mem_be[0]) bmem[mem_addr][7:0]  = mem_wdata[7:0];
          end else begin
            mem_rdata = bmem[mem_addr];
          end
        end
        start = ($urandom_range(0, 3) == 0);
        ins   = 16'($urandom);
      end
      prev_req = mem_req;
      prev_we  = mem_we;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    mem_ack = 1'b0;
    chk("done_seen", 32'(done_cyc >= 0), 32'd1);
    chk("done_lat", 32'(done_cyc), 32'(exp_done));
    chk("err", 32'(err_seen), 32'(exp_err));
    chk("req_cycles", 32'(reqc), 32'(exp_req));
    chk("n_writes", 32'(nwr), 32'(exp_nwr));
    chk("idle_after", 32'({busy, done, mem_req}), 32'd0);
    if (exp_nwr == 1) begin
      chk("wr_addr", 32'(wa), 32'(ad));
      chk("wr_data", 32'(wd), 32'(exp_wd));
      chk("wr_be", 32'(wbe), 32'(exp_be));
    end
    chk("mem_word", 32'(bmem[ad]), 32'(rmem[ad]));
  endtask

  initial begin
    logic [15:0] v;
    logic        late_done;
    int          rw, ww;
    for (int k = 0; k < 256; k++) begin
      v = 16'($urandom);
      bmem[k] = v;
      rmem[k] = v;
    end

    repeat (2) @(negedge clk);
    chk("rst_ctrl", 32'({busy, done, err, mem_req, mem_we}), 32'd0);
    chk("rst_bus", 32'({mem_addr, mem_wdata, mem_be}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_store(16'h0042, 16'hBEEF, 16'h1111, 0, 0);
    chk("word_beef", 32'(bmem[8'h42]), 32'h0000BEEF);

    bmem[8'h10] = 16'h1234; rmem[8'h10] = 16'h1234;
    do_store(16'h0E10, 16'h5555, 16'h00AB, 3, 0);
    chk("byte_hi_ab34", 32'(bmem[8'h10]), 32'h0000AB34);

    bmem[8'h10] = 16'h1234; rmem[8'h10] = 16'h1234;
    do_store(16'h0410, 16'hFF5C, 16'h7777, 1, 2);
    chk("byte_lo_125c", 32'(bmem[8'h10]), 32'h0000125C);

    do_store(16'h0E20, 16'h1357, 16'h2468, NEVER, 0);
    do_store(16'h0030, 16'hCAFE, 16'h0000, 0, NEVER);
    do_store(16'h0C31, 16'h0000, 16'h00EE, 1, NEVER);

    // Asynchronous reset while a write request is outstanding.
    @(negedge clk);
    start = 1'b1; ins = 16'h0055; A_in = 16'hD00D;
    @(negedge clk);
    start = 1'b0;
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_wr", 32'({mem_req, busy, done, err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    late_done = 1'b0;
    mem_ack = 1'b1;
    repeat (5) begin
      @(negedge clk);
      late_done = late_done | done | mem_req;
    end
    mem_ack = 1'b0;
    chk("no_done_after_rst", 32'(late_done), 32'd0);

    do_store(16'h0055, 16'hD00D, 16'h0000, 0, 1);

    for (int n = 0; n < 60; n++) begin
      rw = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 3));
      ww = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 3));
      do_store(16'($urandom), 16'($urandom), 16'($urandom), rw, ww);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
